// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end time-sharing one combinational ALU.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W:0]   req0_a,
    input  logic [W:0]   req0_b,
    input  logic [2:0]   req0_op,
    input  logic [W:0]   req1_a,
    input  logic [W:0]   req1_b,
    input  logic [2:0]   req1_op,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W:0]   rsp_data,
    output logic [3:0]   rsp_flags,
    output logic [W:0]   alu_a,
    output logic [W:0]   alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W:0]   alu_out,
    input  logic         alu_co,
    input  logic         alu_ovf,
    input  logic         alu_z,
`ifdef ALU_ARB_STATS_EN
    input  logic         alu_n,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`else
    input  logic         alu_n
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       g_q, g_d;
    logic       p_q, p_d;
    logic [W:0] a_q, a_d;
    logic [W:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [W:0] res_q, res_d;
    logic [3:0] flg_q, flg_d;

    logic       win_vld;
    logic       win_idx;
    logic       accept;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 1'b0;
        unique case (1'b1)
            (req_valid == 2'b11): begin
                win_vld = 1'b1;
                win_idx = p_q;
            end
            (req_valid == 2'b01): begin
                win_vld = 1'b1;
                win_idx = 1'b0;
            end
            (req_valid == 2'b10): begin
                win_vld = 1'b1;
                win_idx = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = (state_q == IDLE) && win_vld;

    always_comb begin
        req_ready = 2'b00;
        if (accept) req_ready = 2'b01 << win_idx;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d     = win_idx;
                    a_d     = win_idx ? req1_a  : req0_a;
                    b_d     = win_idx ? req1_b  : req0_b;
                    op_d    = win_idx ? req1_op : req0_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                flg_d   = {alu_n, alu_z, alu_co, alu_ovf};
                state_d = RESP;
            end
            RESP: begin
                // Loser of this grant takes priority on the next tie.
                if (rsp_ready[g_q]) begin
                    p_d     = ~g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            p_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = op_q;
    assign rsp_data  = res_q;
    assign rsp_flags = flg_q;

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == RESP) rsp_valid = 2'b01 << g_q;
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && !win_idx && cnt0_q != 16'hFFFF) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (accept && win_idx && cnt1_q != 16'hFFFF) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a stand-in 8-function ALU.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_share_arbiter;

    localparam int W = 7;

    typedef struct packed {
        logic [1:0] who;
        logic [W:0] data;
        logic [3:0] flg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W:0]   req0_a = '0, req0_b = '0;
    logic [2:0]   req0_op = '0;
    logic [W:0]   req1_a = '0, req1_b = '0;
    logic [2:0]   req1_op = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b11;
    logic [W:0]   rsp_data;
    logic [3:0]   rsp_flags;
    logic [W:0]   alu_a, alu_b;
    logic [2:0]   alu_ctrl;
    logic [W:0]   alu_out;
    logic         alu_co, alu_ovf, alu_z, alu_n;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf),
`ifdef ALU_ARB_STATS_EN
        .alu_z(alu_z), .alu_n(alu_n),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`else
        .alu_z(alu_z), .alu_n(alu_n)
`endif
    );

    // Stand-in ALU: 0 add, 1 a-b, 2 b-a, 3 and, 4 or, 5 xor, 6 nor, 7 pass a
    logic [W+1:0] s;
    always_comb begin
        s = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            3'd0: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_ovf = (alu_a[W] == alu_b[W]) && (s[W] != alu_a[W]);
            end
            3'd1: begin
                s = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                alu_ovf = (alu_a[W] != alu_b[W]) && (s[W] != alu_a[W]);
            end
            3'd2: begin
                s = {1'b0, alu_b} + {1'b0, ~alu_a} + 9'd1;
                alu_ovf = (alu_a[W] != alu_b[W]) && (s[W] != alu_b[W]);
            end
            3'd3: s = {1'b0, alu_a & alu_b};
            3'd4: s = {1'b0, alu_a | alu_b};
            3'd5: s = {1'b0, alu_a ^ alu_b};
            3'd6: s = {1'b0, ~(alu_a | alu_b)};
            default: s = {1'b0, alu_a};
        endcase
    end
    assign alu_out = s[W:0];
    assign alu_co  = s[W+1];
    assign alu_z   = (s[W:0] == '0);
    assign alu_n   = s[W];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: pops on every response handshake.
    always @(negedge clk) begin
        if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_who", {30'd0, rsp_valid}, {30'd0, e.who});
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flg});
            end
        end
    end

    task automatic wait_accept(input logic [1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, m});
    endtask

    task automatic set_req(input bit idx, input logic [W:0] a,
                           input logic [W:0] b, input logic [2:0] op);
        if (idx) begin
            req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // One full operation with immediate ack; checks latency too.
    task automatic issue(input bit idx, input bit both,
                         input logic [W:0] a, input logic [W:0] b,
                         input logic [2:0] op, input logic [W:0] d,
                         input logic [3:0] f);
        logic [1:0] m;
        m = 2'b01 << idx;
        set_req(idx, a, b, op);
        req_valid = both ? 2'b11 : m;
        wait_accept(m);
        sb.push_back('{who: m, data: d, flg: f});
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("exec_rv", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("resp_rv", {30'd0, rsp_valid}, {30'd0, m});
        @(negedge clk);
        chk("idle_rv", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        @(posedge clk);
        #1;

        issue(1'b0, 1'b0, 8'h05, 8'h03, 3'd0, 8'h08, 4'b0000);
        issue(1'b1, 1'b0, 8'h03, 8'h03, 3'd1, 8'h00, 4'b0110);
        issue(1'b1, 1'b0, 8'h01, 8'h00, 3'd2, 8'hFF, 4'b1000);

        // Fairness: both held valid for four grants.
        do_reset();
        set_req(1'b0, 8'h7F, 8'h01, 3'd0);
        set_req(1'b1, 8'hF0, 8'h0F, 3'd3);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] m;
            m = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_accept(m);
            if (k % 2 == 0) sb.push_back('{who: 2'b01, data: 8'h80, flg: 4'b1001});
            else sb.push_back('{who: 2'b10, data: 8'h00, flg: 4'b0100});
            @(posedge clk);
            if (k == 3) #1 req_valid = 2'b00;
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure in RESP with both requesters valid.
        rsp_ready = 2'b00;
        set_req(1'b0, 8'h80, 8'h80, 3'd0);
        req_valid = 2'b11;
        wait_accept(2'b01);
        sb.push_back('{who: 2'b01, data: 8'h00, flg: 4'b0111});
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv", {30'd0, rsp_valid}, 32'd1);
            chk("bp_data", {24'd0, rsp_data}, 32'h00);
            chk("bp_flags", {28'd0, rsp_flags}, 32'h7);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp_wrong_ack", {30'd0, rsp_valid}, 32'd1);
        rsp_ready = 2'b01;
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp_done", {30'd0, rsp_valid}, 32'd0);
        rsp_ready = 2'b11;
        @(posedge clk);
        #1;

        // Reset during EXEC drops the request; priority returns to 0.
        set_req(1'b1, 8'h11, 8'h22, 3'd4);
        req_valid = 2'b10;
        wait_accept(2'b10);
        @(posedge clk);
        #1 req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_rst_rv", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        set_req(1'b1, 8'h11, 8'h22, 3'd4);
        issue(1'b0, 1'b1, 8'h0A, 8'h0C, 3'd5, 8'h06, 4'b0000);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        @(negedge clk);
        chk("cnt0_rst", {16'd0, grant_cnt0}, 32'd0);
        chk("cnt1_rst", {16'd0, grant_cnt1}, 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b0, 8'h01, 8'h02, 3'd0, 8'h03, 4'b0000);
        end
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 1'b0, 8'hFF, 8'h00, 3'd7, 8'hFF, 4'b1000);
        end
        @(negedge clk);
        chk("cnt0", {16'd0, grant_cnt0}, 32'd3);
        chk("cnt1", {16'd0, grant_cnt1}, 32'd2);
        @(posedge clk);
        #1 do_reset();
        @(negedge clk);
        chk("cnt0_clr", {16'd0, grant_cnt0}, 32'd0);
        chk("cnt1_clr", {16'd0, grant_cnt1}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
